cnu_expand: RTL and testbench
=============================

# cnu_expand

Check-node message expander for the LDPC decoder. It accepts one compressed check-node record per check node: min1, min2, min1 index, total sign and per-edge input signs. It then serially emits the `deg` check-to-variable messages, one edge per beat, toward the variable-node side. It is the decompression end of the min-finding CNU datapath, turning the two-minimum summary back into per-edge offset-min-sum messages.

## Interface
Parameters:
- `data_w`, 8: magnitude width of min1/min2 and output magnitude.
- `idx_w`, 8: edge index width; `deg` must be ≤ 2^idx_w.
- `deg`, 8: check-node degree (edges per record), ≥ 2.
- `offset`, 1: offset-min-sum correction subtracted from each magnitude.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset. It is synchronous and active-high.
- `in_valid` input 1: a record is present on the in_* inputs.
- `in_ready` output 1: the block can accept a record this cycle.
- `in_min1` input data_w: smallest input magnitude.
- `in_min2` input data_w: second-smallest input magnitude.
- `in_idx` input idx_w: edge index of min1.
- `in_sign_total` input 1: XOR of all input signs.
- `in_signs` input deg: per-edge input sign; bit e belongs to edge e.
- `out_valid` output 1: an output beat is present.
- `out_ready` input 1: the consumer accepts the beat.
- `out_mag` output data_w: output message magnitude.
- `out_sign` output 1: output message sign (1 = negative).
- `out_edge` output idx_w: edge index of this beat.
- `out_last` output 1: high on the beat for edge deg-1.
- `idx_err` output 1: one-cycle pulse when an accepted record has in_idx ≥ deg.

## Operation
- Two states, IDLE and EMIT.
- **IDLE:** in_ready=1. On in_valid && in_ready, the block registers the record, goes to EMIT and sets the edge counter to 0.
- **EMIT:** presents the beat for the current edge e, from registered outputs.
  - out_mag = sat0(sel − offset), where sel = min2 if e == idx, otherwise min1.
  - sat0 clamps negative results to 0. Compute the subtraction at data_w+1 bits.
  - out_sign = sign_total ^ signs[e].
  - out_edge = e.
  - out_last = (e == deg−1).
- **Advance:** the counter advances only on out_valid && out_ready.
  - On a last-beat handshake with no new record accepted: go to IDLE, out_valid drops.
- **Back-to-back:** in_ready = IDLE || (out_valid && out_ready && out_last).
  - A record accepted on the last-beat handshake cycle starts edge 0 on the next cycle.
  - There is no bubble between records.
- **Stability:** while out_valid && !out_ready, all out_* stay stable.
- **Independence:** the registered record is independent of the in_* values after acceptance. in_* may change freely.
- **Bad index:** in_idx ≥ deg is not fatal.
  - No edge matches, so every edge carries min1 − offset.
  - idx_err pulses on the cycle after acceptance.
- **Reset values:** out_valid=0, in_ready=1 (IDLE), out_mag=0, out_sign=0, out_edge=0, out_last=0, idx_err=0, counter=0.

## Timing
- Latency: a record accepted at cycle t gives edge 0 valid at t+1.
- Throughput: one beat per cycle under continuous out_ready, which is deg cycles per record.
- in_ready is combinational from state and out_ready.
- out_* and idx_err are registered.
- rst high in any cycle, including mid-burst:
  - The next cycle shows reset values.
  - The partial record is discarded.
  - A record presented while rst is high is not accepted.
- in_valid arriving while in EMIT and not on the last handshake is held off by in_ready=0. The producer must hold its record.

## Test plan
All scenarios use deg=8, data_w=8, offset=1.
- **Basic record:** min1=5, min2=9, idx=3, sign_total=1, signs=8'b00000101, out_ready=1 -> beats at t+1..t+8:
  - edges 0..7
  - mags 4,4,4,8,4,4,4,4
  - signs 0,1,0,1,1,1,1,1
  - out_last only on edge 7
  - in_ready=0 during t+1..t+7 (edges 0..6), in_ready=1 on the edge-7 beat
- **Backpressure:** same record with out_ready low on the 2nd–4th beat cycles -> edge 1 held stable with mag 4, sign 1 for 3 cycles, then edges continue in order. No beat is lost or duplicated.
- **Back-to-back:** a second record (min1=2, min2=3, idx=0, sign_total=0, signs=0) is valid during the first record's last beat. It is accepted that cycle and yields 16 consecutive valid beats. The second record's mags are 2,1,1,1,1,1,1,1, all with sign 0.
- **Saturation:** min1=0, min2=1, idx=5 -> all mags 0, with no wrap to 255.
- **Bad index:** idx=10 -> idx_err pulses one cycle, and all 8 mags equal min1−1.
- **Reset mid-burst:** rst after the third beat -> next cycle out_valid=0, in_ready=1. A new record after reset starts at out_edge=0.

Source files
------------

// File: rtl/cnu_expand.sv
// Check-node message expander.
// Takes one compressed check-node record (min1, min2, min1 index, total sign,
// per-edge signs) and serially emits deg offset-min-sum messages, one edge per
// beat, with a ready/valid handshake on both sides.
module cnu_expand #(
  parameter int unsigned data_w = 8,
  parameter int unsigned idx_w  = 8,
  parameter int unsigned deg    = 8,
  parameter int unsigned offset = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Record input
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_min1,
  input  logic [data_w-1:0] in_min2,
  input  logic [idx_w-1:0]  in_idx,
  input  logic              in_sign_total,
  input  logic [deg-1:0]    in_signs,
  // Per-edge message output
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] out_mag,
  output logic              out_sign,
  output logic [idx_w-1:0]  out_edge,
  output logic              out_last,
  output logic              idx_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  localparam logic [idx_w-1:0] LastEdge  = idx_w'(deg - 1);
  localparam logic [idx_w-1:0] FirstEdge = '0;
  localparam logic [data_w:0]  OffExt    = (data_w + 1)'(offset);

  // Offset-min-sum magnitude for edge e; the subtraction is one bit wider so
  // an underflow shows up in the top bit and clamps to zero.
  function automatic logic [data_w-1:0] calc_mag(input logic [data_w-1:0] m1,
                                                 input logic [data_w-1:0] m2,
                                                 input logic [idx_w-1:0]  mi,
                                                 input logic [idx_w-1:0]  e);
    logic [data_w:0] diff;
    diff = {1'b0, ((e == mi) ? m2 : m1)} - OffExt;
    return diff[data_w] ? '0 : diff[data_w-1:0];
  endfunction

  // Extrinsic sign: total sign with this edge's own sign removed.
  function automatic logic calc_sign(input logic           st,
                                     input logic [deg-1:0] s,
                                     input logic [idx_w-1:0] e);
    logic [deg-1:0] sh;
    sh = s >> e;
    return st ^ sh[0];
  endfunction

  // Registered record and output state
  logic [0:0]        state_q, state_d;
  logic [data_w-1:0] min1_q, min1_d;
  logic [data_w-1:0] min2_q, min2_d;
  logic [idx_w-1:0]  idx_q, idx_d;
  logic              sign_total_q, sign_total_d;
  logic [deg-1:0]    signs_q, signs_d;
  logic [idx_w-1:0]  cnt_q, cnt_d;
  logic [data_w-1:0] mag_q, mag_d;
  logic              sign_q, sign_d;
  logic              last_q, last_d;
  logic              idx_err_q, idx_err_d;

  logic              accept;
  logic              advance;
  logic              bad_idx;
  logic [idx_w-1:0]  cnt_nxt;

  // Handshake decode; a new record may enter on the final beat's handshake.
  always_comb begin
    out_valid = (state_q == StEmit);
    advance   = out_valid && out_ready;
    in_ready  = (state_q == StIdle) || (advance && last_q);
    accept    = in_valid && in_ready;
    bad_idx   = (32'(in_idx) >= deg);
    cnt_nxt   = cnt_q + idx_w'(1);
  end

  // Next-state: load a record (edge 0 beat precomputed) or step to the next edge.
  always_comb begin
    state_d      = state_q;
    min1_d       = min1_q;
    min2_d       = min2_q;
    idx_d        = idx_q;
    sign_total_d = sign_total_q;
    signs_d      = signs_q;
    cnt_d        = cnt_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    last_d       = last_q;
    idx_err_d    = 1'b0;

    if (accept) begin
      state_d      = StEmit;
      min1_d       = in_min1;
      min2_d       = in_min2;
      idx_d        = in_idx;
      sign_total_d = in_sign_total;
      signs_d      = in_signs;
      cnt_d        = FirstEdge;
      mag_d        = calc_mag(in_min1, in_min2, in_idx, FirstEdge);
      sign_d       = calc_sign(in_sign_total, in_signs, FirstEdge);
      last_d       = (FirstEdge == LastEdge);
      idx_err_d    = bad_idx;
    end else if (advance) begin
      if (last_q) begin
        state_d = StIdle;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_nxt;
        mag_d  = calc_mag(min1_q, min2_q, idx_q, cnt_nxt);
        sign_d = calc_sign(sign_total_q, signs_q, cnt_nxt);
        last_d = (cnt_nxt == LastEdge);
      end
    end
  end

  // State registers with synchronous reset; reset discards any partial record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      min1_q       <= '0;
      min2_q       <= '0;
      idx_q        <= '0;
      sign_total_q <= 1'b0;
      signs_q      <= '0;
      cnt_q        <= '0;
      mag_q        <= '0;
      sign_q       <= 1'b0;
      last_q       <= 1'b0;
      idx_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      min1_q       <= min1_d;
      min2_q       <= min2_d;
      idx_q        <= idx_d;
      sign_total_q <= sign_total_d;
      signs_q      <= signs_d;
      cnt_q        <= cnt_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      last_q       <= last_d;
      idx_err_q    <= idx_err_d;
    end
  end

  assign out_mag  = mag_q;
  assign out_sign = sign_q;
  assign out_edge = cnt_q;
  assign out_last = last_q;
  assign idx_err  = idx_err_q;

endmodule

// File: tb/tb_cnu_expand.sv
// Directed bench for cnu_expand (deg=8, data_w=8, offset=1).
module tb_cnu_expand;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_min1;
  logic [7:0] in_min2;
  logic [7:0] in_idx;
  logic       in_sign_total;
  logic [7:0] in_signs;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mag;
  logic       out_sign;
  logic [7:0] out_edge;
  logic       out_last;
  logic       idx_err;

  int vectors = 0;
  int miscompares = 0;

  cnu_expand #(
    .data_w(8),
    .idx_w (8),
    .deg   (8),
    .offset(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_min1      (in_min1),
    .in_min2      (in_min2),
    .in_idx       (in_idx),
    .in_sign_total(in_sign_total),
    .in_signs     (in_signs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mag      (out_mag),
    .out_sign     (out_sign),
    .out_edge     (out_edge),
    .out_last     (out_last),
    .idx_err      (idx_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a record for one edge, then scramble the inputs.
  task automatic send(input logic [7:0] m1, input logic [7:0] m2, input logic [7:0] ix,
                      input logic st, input logic [7:0] sg);
    in_min1 = m1; in_min2 = m2; in_idx = ix; in_sign_total = st; in_signs = sg;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_min1 = 8'hA5; in_min2 = 8'h5A; in_idx = 8'h03; in_sign_total = 1'b1; in_signs = 8'hC3;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_min1 = '0; in_min2 = '0; in_idx = '0; in_sign_total = 1'b0; in_signs = '0;
    step(); step();
    rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, out_mag, out_sign, out_edge, out_last, idx_err} !==
        {1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: valid=%b ready=%b mag=%0d sign=%b edge=%0d last=%b err=%b, want 0 1 0 0 0 0 0",
               out_valid, in_ready, out_mag, out_sign, out_edge, out_last, idx_err);
    end
  endtask

  task automatic test_basic();
    logic [7:0] mags [8];
    logic       sgns [8];
    mags = '{8'd4, 8'd4, 8'd4, 8'd8, 8'd4, 8'd4, 8'd4, 8'd4};
    sgns = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    send(8'd5, 8'd9, 8'd3, 1'b1, 8'b0000_0101);
    for (int e = 0; e < 8; e++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'(e) || out_mag !== mags[e] ||
          out_sign !== sgns[e] || out_last !== (e == 7) || in_ready !== (e == 7) ||
          idx_err !== 1'b0) begin
        miscompares++;
        $display("FAIL basic e%0d: v=%b edge=%0d mag=%0d sign=%b last=%b rdy=%b err=%b, want 1 %0d %0d %b %b %b 0",
                 e, out_valid, out_edge, out_mag, out_sign, out_last, in_ready, idx_err,
                 e, mags[e], sgns[e], e == 7, e == 7);
      end
      step();
    end
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_idle: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] mags [8];
    logic       sgns [8];
    mags = '{8'd4, 8'd4, 8'd4, 8'd8, 8'd4, 8'd4, 8'd4, 8'd4};
    sgns = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    send(8'd5, 8'd9, 8'd3, 1'b1, 8'b0000_0101);
    vectors++;
    if (out_valid !== 1'b1 || out_edge !== 8'd0) begin
      miscompares++;
      $display("FAIL bp_first: valid=%b edge=%0d, want 1 0", out_valid, out_edge);
    end
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'd1 || out_mag !== 8'd4 || out_sign !== 1'b1 ||
          out_last !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: v=%b edge=%0d mag=%0d sign=%b last=%b rdy=%b, want 1 1 4 1 0 0",
                 c, out_valid, out_edge, out_mag, out_sign, out_last, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    for (int e = 1; e < 8; e++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'(e) || out_mag !== mags[e] ||
          out_sign !== sgns[e] || out_last !== (e == 7)) begin
        miscompares++;
        $display("FAIL bp_resume e%0d: v=%b edge=%0d mag=%0d sign=%b last=%b, want 1 %0d %0d %b %b",
                 e, out_valid, out_edge, out_mag, out_sign, out_last, e, mags[e], sgns[e], e == 7);
      end
      step();
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mags [16];
    logic       sgns [16];
    mags = '{8'd4, 8'd4, 8'd4, 8'd8, 8'd4, 8'd4, 8'd4, 8'd4,
             8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    sgns = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    send(8'd5, 8'd9, 8'd3, 1'b1, 8'b0000_0101);
    for (int b = 0; b < 16; b++) begin
      if (b == 7) begin
        in_min1 = 8'd2; in_min2 = 8'd3; in_idx = 8'd0; in_sign_total = 1'b0; in_signs = 8'd0;
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready: in_ready=%b on last beat, want 1", in_ready);
        end
      end
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'(b % 8) || out_mag !== mags[b] ||
          out_sign !== sgns[b] || out_last !== (b % 8 == 7)) begin
        miscompares++;
        $display("FAIL b2b beat%0d: v=%b edge=%0d mag=%0d sign=%b last=%b, want 1 %0d %0d %b %b",
                 b, out_valid, out_edge, out_mag, out_sign, out_last, b % 8, mags[b], sgns[b],
                 b % 8 == 7);
      end
      step();
      if (b == 7) begin
        in_valid = 1'b0;
        in_min1 = 8'hFF; in_min2 = 8'hFF; in_idx = 8'd6; in_sign_total = 1'b1; in_signs = 8'hFF;
      end
    end
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    send(8'd0, 8'd1, 8'd5, 1'b0, 8'd0);
    for (int e = 0; e < 8; e++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'(e) || out_mag !== 8'd0 || out_sign !== 1'b0) begin
        miscompares++;
        $display("FAIL sat e%0d: v=%b edge=%0d mag=%0d sign=%b, want 1 %0d 0 0",
                 e, out_valid, out_edge, out_mag, out_sign, e);
      end
      step();
    end
  endtask

  task automatic test_bad_index();
    out_ready = 1'b1;
    send(8'd7, 8'd12, 8'd10, 1'b0, 8'b1111_0000);
    for (int e = 0; e < 8; e++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'(e) || out_mag !== 8'd6 ||
          out_sign !== (e >= 4) || idx_err !== (e == 0)) begin
        miscompares++;
        $display("FAIL badidx e%0d: v=%b edge=%0d mag=%0d sign=%b err=%b, want 1 %0d 6 %b %b",
                 e, out_valid, out_edge, out_mag, out_sign, idx_err, e, e >= 4, e == 0);
      end
      step();
    end
    vectors++;
    if (idx_err !== 1'b0) begin
      miscompares++;
      $display("FAIL badidx_clear: idx_err=%b, want 0", idx_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b1;
    send(8'd5, 8'd9, 8'd3, 1'b1, 8'b0000_0101);
    step(); step();
    vectors++;
    if (out_valid !== 1'b1 || out_edge !== 8'd2) begin
      miscompares++;
      $display("FAIL rstmid_pre: valid=%b edge=%0d, want 1 2", out_valid, out_edge);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_edge !== 8'd0 || out_mag !== 8'd0 ||
        out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_post: v=%b rdy=%b edge=%0d mag=%0d last=%b, want 0 1 0 0 0",
               out_valid, in_ready, out_edge, out_mag, out_last);
    end
    // A record offered during reset must be ignored.
    in_min1 = 8'd3; in_min2 = 8'd4; in_idx = 8'd0; in_sign_total = 1'b0; in_signs = 8'd0;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ignore: out_valid=%b after record offered in reset, want 0", out_valid);
    end
    send(8'd3, 8'd4, 8'd0, 1'b0, 8'd0);
    for (int e = 0; e < 8; e++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_edge !== 8'(e) || out_mag !== ((e == 0) ? 8'd3 : 8'd2)) begin
        miscompares++;
        $display("FAIL rstmid_new e%0d: v=%b edge=%0d mag=%0d, want 1 %0d %0d",
                 e, out_valid, out_edge, out_mag, e, (e == 0) ? 3 : 2);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_bad_index();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
